player_action_sequencer: RTL and testbench

Per-step controller for the two-player maze datapath. On each game tick it latches both players' commands and shares the single maze-wall read port between them, one player after the other. It applies moves against wall data and resolves SHOOT by scanning cells one at a time instead of using a combinational loop. It owns the player positions, facing directions and sticky victory code that feed the vision, LED-matrix and seven-segment logic.

---
 rtl/maze_pkg.sv | 57 +++++
 rtl/player_action_sequencer_if.sv | 31 +++
 rtl/maze_step_calc.sv | 41 ++++
 rtl/player_action_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_player_action_sequencer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// +----------------------------------------------------------------------------+
// | maze_pkg: shared constants and types for the two-player maze sequencer.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package maze_pkg;

  localparam int MAZE_ROWS = 16;
  localparam int MAZE_COLS = 24;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 5;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_SHOOT = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL      = 3'd1,
    ST_RD       = 3'd2,
    ST_CHK      = 3'd3,
    ST_SCAN_RD  = 3'd4,
    ST_SCAN_CHK = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } seq_state_t;

  localparam logic [1:0] VIC_NONE = 2'd0;
  localparam logic [1:0] VIC_P1   = 2'd1;
  localparam logic [1:0] VIC_P2   = 2'd2;

  // Only meaningful for the four move commands.
  function automatic dir_t cmd_to_dir(input logic [2:0] cmd);
    case (cmd)
      CMD_UP:   return DIR_UP;
      CMD_DOWN: return DIR_DOWN;
      CMD_LEFT: return DIR_LEFT;
      default:  return DIR_RIGHT;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_action_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | player_action_sequencer_if: single maze-wall read port (1-cycle latency).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface player_action_sequencer_if;
  import maze_pkg::*;

  logic [ROW_W-1:0] maze_rd_row;
  logic [COL_W-1:0] maze_rd_col;
  logic             maze_rd_en;
  logic             maze_rd_data;

  modport master (
    output maze_rd_row,
    output maze_rd_col,
    output maze_rd_en,
    input  maze_rd_data
  );

  modport slave (
    input  maze_rd_row,
    input  maze_rd_col,
    input  maze_rd_en,
    output maze_rd_data
  );

endinterface

`default_nettype wire

// File: rtl/maze_step_calc.sv
// +----------------------------------------------------------------------------+
// | maze_step_calc: one-cell step in a direction with bounds detection.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module maze_step_calc
  import maze_pkg::*;
#(
  parameter int ROWS = MAZE_ROWS,
  parameter int COLS = MAZE_COLS
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  dir_t             dir,
  output logic [ROW_W-1:0] next_row,
  output logic [COL_W-1:0] next_col,
  output logic             out_of_bounds
);

  // One extra bit so that 0-1 and max+1 land above the legal range.
  logic [ROW_W:0] row_x;
  logic [COL_W:0] col_x;

  always_comb begin
    row_x = {1'b0, row};
    col_x = {1'b0, col};
    case (dir)
      DIR_UP:    row_x = {1'b0, row} - (ROW_W+1)'(1);
      DIR_DOWN:  row_x = {1'b0, row} + (ROW_W+1)'(1);
      DIR_LEFT:  col_x = {1'b0, col} - (COL_W+1)'(1);
      default:   col_x = {1'b0, col} + (COL_W+1)'(1);
    endcase
    out_of_bounds = (row_x > (ROW_W+1)'(ROWS-1)) || (col_x > (COL_W+1)'(COLS-1));
    next_row      = row_x[ROW_W-1:0];
    next_col      = col_x[COL_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/player_action_sequencer.sv
// +----------------------------------------------------------------------------+
// | player_action_sequencer: per-tick move/shoot sequencer sharing one wall    |
// | read port between two players. Option macro: ALT_PRIORITY_EN. Rev 1.0     |
// +----------------------------------------------------------------------------+
`default_nettype none

module player_action_sequencer
  import maze_pkg::*;
#(
  parameter int ROWS    = MAZE_ROWS,
  parameter int COLS    = MAZE_COLS,
  parameter int P1_ROW0 = 2,
  parameter int P1_COL0 = 8,
  parameter int P2_ROW0 = 8,
  parameter int P2_COL0 = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [2:0]                  p1_cmd,
  input  logic [2:0]                  p2_cmd,
  player_action_sequencer_if.master   maze,
  output logic [ROW_W-1:0]            p1_row,
  output logic [COL_W-1:0]            p1_col,
  output logic [ROW_W-1:0]            p2_row,
  output logic [COL_W-1:0]            p2_col,
  output logic [1:0]                  p1_dir,
  output logic [1:0]                  p2_dir,
  output logic [1:0]                  victory,
  output logic                        busy,
  output logic                        step_done
);

  seq_state_t       state_q, state_d;
  logic             cur_p2_q, cur_p2_d;
  logic             second_q, second_d;
  logic             first_p2_q, first_p2_d;
  logic [2:0]       cmd1_q, cmd1_d, cmd2_q, cmd2_d;
  logic [ROW_W-1:0] p1_row_q, p1_row_d, p2_row_q, p2_row_d;
  logic [COL_W-1:0] p1_col_q, p1_col_d, p2_col_q, p2_col_d;
  dir_t             p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
  logic [1:0]       victory_q, victory_d;
  logic [ROW_W-1:0] cur_row_q, cur_row_d;
  logic [COL_W-1:0] cur_col_q, cur_col_d;
  logic             rd_en_q, rd_en_d;

  logic [2:0]       cur_cmd;
  logic [ROW_W-1:0] my_row, opp_row, calc_row, nxt_row;
  logic [COL_W-1:0] my_col, opp_col, calc_col, nxt_col;
  dir_t             my_dir, calc_dir;
  logic             is_move, nxt_oob, hit_opp, scan_step;

  // The acting player's view; the scan path steps from the cursor instead.
  always_comb begin
    cur_cmd  = cur_p2_q ? cmd2_q   : cmd1_q;
    my_row   = cur_p2_q ? p2_row_q : p1_row_q;
    my_col   = cur_p2_q ? p2_col_q : p1_col_q;
    my_dir   = cur_p2_q ? p2_dir_q : p1_dir_q;
    opp_row  = cur_p2_q ? p1_row_q : p2_row_q;
    opp_col  = cur_p2_q ? p1_col_q : p2_col_q;
    is_move  = cur_cmd inside {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
    calc_row = (state_q == ST_SCAN_CHK) ? cur_row_q : my_row;
    calc_col = (state_q == ST_SCAN_CHK) ? cur_col_q : my_col;
    calc_dir = is_move ? cmd_to_dir(cur_cmd) : my_dir;
  end

  maze_step_calc #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_step (
    .row           (calc_row),
    .col           (calc_col),
    .dir           (calc_dir),
    .next_row      (nxt_row),
    .next_col      (nxt_col),
    .out_of_bounds (nxt_oob)
  );

  assign hit_opp = (nxt_row == opp_row) && (nxt_col == opp_col);

  always_comb begin
    state_d    = state_q;
    cur_p2_d   = cur_p2_q;
    second_d   = second_q;
    first_p2_d = first_p2_q;
    cmd1_d     = cmd1_q;
    cmd2_d     = cmd2_q;
    p1_row_d   = p1_row_q;
    p1_col_d   = p1_col_q;
    p2_row_d   = p2_row_q;
    p2_col_d   = p2_col_q;
    p1_dir_d   = p1_dir_q;
    p2_dir_d   = p2_dir_q;
    victory_d  = victory_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    rd_en_d    = 1'b0;
    scan_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tick && (victory_q == VIC_NONE)) begin
          cmd1_d   = p1_cmd;
          cmd2_d   = p2_cmd;
          cur_p2_d = first_p2_q;
          second_d = 1'b0;
          state_d  = ST_SEL;
        end
      end
      ST_SEL: begin
        if (is_move) begin
          if (cur_p2_q) p2_dir_d = calc_dir;
          else          p1_dir_d = calc_dir;
          if (nxt_oob || hit_opp) begin
            state_d = ST_NEXT;
          end else begin
            cur_row_d = nxt_row;
            cur_col_d = nxt_col;
            rd_en_d   = 1'b1;
            state_d   = ST_RD;
          end
        end else if (cur_cmd == CMD_SHOOT) begin
          scan_step = 1'b1;
        end else begin
          state_d = ST_NEXT;
        end
      end
      ST_RD:      state_d = ST_CHK;
      ST_CHK: begin
        if (!maze.maze_rd_data) begin
          if (cur_p2_q) begin
            p2_row_d = cur_row_q;
            p2_col_d = cur_col_q;
          end else begin
            p1_row_d = cur_row_q;
            p1_col_d = cur_col_q;
          end
        end
        state_d = ST_NEXT;
      end
      ST_SCAN_RD: state_d = ST_SCAN_CHK;
      ST_SCAN_CHK: begin
        if (maze.maze_rd_data) state_d = ST_NEXT;
        else                   scan_step = 1'b1;
      end
      ST_NEXT: begin
        if (!second_q) begin
          second_d = 1'b1;
          cur_p2_d = ~cur_p2_q;
          state_d  = ST_SEL;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
`ifdef ALT_PRIORITY_EN
        first_p2_d = ~first_p2_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // One scan iteration: evaluate the next cell along the shooter's facing.
    if (scan_step) begin
      if (nxt_oob) begin
        state_d = ST_NEXT;
      end else if (hit_opp) begin
        victory_d = cur_p2_q ? VIC_P2 : VIC_P1;
        state_d   = ST_DONE;
      end else begin
        cur_row_d = nxt_row;
        cur_col_d = nxt_col;
        rd_en_d   = 1'b1;
        state_d   = ST_SCAN_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_p2_q   <= 1'b0;
      second_q   <= 1'b0;
      first_p2_q <= 1'b0;
      cmd1_q     <= CMD_NONE;
      cmd2_q     <= CMD_NONE;
      p1_row_q   <= ROW_W'(P1_ROW0);
      p1_col_q   <= COL_W'(P1_COL0);
      p2_row_q   <= ROW_W'(P2_ROW0);
      p2_col_q   <= COL_W'(P2_COL0);
      p1_dir_q   <= DIR_UP;
      p2_dir_q   <= DIR_UP;
      victory_q  <= VIC_NONE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_p2_q   <= cur_p2_d;
      second_q   <= second_d;
      first_p2_q <= first_p2_d;
      cmd1_q     <= cmd1_d;
      cmd2_q     <= cmd2_d;
      p1_row_q   <= p1_row_d;
      p1_col_q   <= p1_col_d;
      p2_row_q   <= p2_row_d;
      p2_col_q   <= p2_col_d;
      p1_dir_q   <= p1_dir_d;
      p2_dir_q   <= p2_dir_d;
      victory_q  <= victory_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign maze.maze_rd_row = cur_row_q;
  assign maze.maze_rd_col = cur_col_q;
  assign maze.maze_rd_en  = rd_en_q;
  assign p1_row    = p1_row_q;
  assign p1_col    = p1_col_q;
  assign p2_row    = p2_row_q;
  assign p2_col    = p2_col_q;
  assign p1_dir    = p1_dir_q;
  assign p2_dir    = p2_dir_q;
  assign victory   = victory_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign step_done = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_player_action_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_player_action_sequencer: directed bench with a behavioural wall memory. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_player_action_sequencer;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_UP    = 3'd1;
  localparam logic [2:0] C_DOWN  = 3'd2;
  localparam logic [2:0] C_LEFT  = 3'd3;
  localparam logic [2:0] C_RIGHT = 3'd4;
  localparam logic [2:0] C_SHOOT = 3'd5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] p1_cmd = 3'd0;
  logic [2:0] p2_cmd = 3'd0;
  logic [3:0] p1_row, p2_row;
  logic [4:0] p1_col, p2_col;
  logic [1:0] p1_dir, p2_dir, victory;
  logic       busy, step_done;

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0;
  logic wall [0:15][0:23];

  player_action_sequencer_if mif ();

  player_action_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .p1_cmd    (p1_cmd),
    .p2_cmd    (p2_cmd),
    .maze      (mif),
    .p1_row    (p1_row),
    .p1_col    (p1_col),
    .p2_row    (p2_row),
    .p2_col    (p2_col),
    .p1_dir    (p1_dir),
    .p2_dir    (p2_dir),
    .victory   (victory),
    .busy      (busy),
    .step_done (step_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.maze_rd_en && (mif.maze_rd_col < 5'd24))
      mif.maze_rd_data <= wall[mif.maze_rd_row][mif.maze_rd_col];
    else
      mif.maze_rd_data <= 1'b0;
    if (mif.maze_rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pos(input string tag, input logic [3:0] r1, input logic [4:0] c1,
                           input logic [3:0] r2, input logic [4:0] c2);
    check({tag, "_p1_row"}, 32'(p1_row), 32'(r1));
    check({tag, "_p1_col"}, 32'(p1_col), 32'(c1));
    check({tag, "_p2_row"}, 32'(p2_row), 32'(r2));
    check({tag, "_p2_col"}, 32'(p2_col), 32'(c2));
  endtask

  // Latency counts rising edges after the edge that accepts the tick.
  task automatic do_step(input logic [2:0] c1, input logic [2:0] c2, input bit retick,
                         output int lat, output int nrd);
    int rd0;
    rd0    = rd_cnt;
    p1_cmd = c1;
    p2_cmd = c2;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick = retick;
    lat  = 0;
    check("busy_after_tick", 32'(busy), 32'd1);
    while ((step_done !== 1'b1) && (lat < 200)) begin
      @(posedge clk); #1;
      lat++;
      tick = 1'b0;
    end
    check("step_in_time", 32'(lat < 200), 32'd1);
    nrd = rd_cnt - rd0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nrd, rd0, guard;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 24; c++)
        wall[r][c] = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_pos("reset", 4'd2, 5'd8, 4'd8, 5'd10);
    check("reset_p1_dir", 32'(p1_dir), 32'd0);
    check("reset_p2_dir", 32'(p2_dir), 32'd0);
    check("reset_victory", 32'(victory), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_step_done", 32'(step_done), 32'd0);
    check("reset_rd_en", 32'(mif.maze_rd_en), 32'd0);

    // NONE/NONE with an extra tick held during the step, which must be ignored.
    do_step(C_NONE, C_NONE, 1'b1, lat, nrd);
    check("none_latency", 32'(lat), 32'd4);
    check("none_reads", 32'(nrd), 32'd0);
    check("none_no_retrigger", 32'(busy), 32'd0);
    check_pos("none", 4'd2, 5'd8, 4'd8, 5'd10);

    do_step(C_RIGHT, C_UP, 1'b0, lat, nrd);
    check_pos("move2", 4'd2, 5'd9, 4'd7, 5'd10);
    check("move2_p1_dir", 32'(p1_dir), 32'd3);
    check("move2_p2_dir", 32'(p2_dir), 32'd0);
    check("move2_reads", 32'(nrd), 32'd2);
    check("move2_latency", 32'(lat), 32'd8);

    do_step(C_LEFT, C_NONE, 1'b0, lat, nrd);
    check("back_p1_dir", 32'(p1_dir), 32'd2);

    wall[1][8] = 1'b1;
    do_step(C_UP, C_NONE, 1'b0, lat, nrd);
    check_pos("wall_up", 4'd2, 5'd8, 4'd7, 5'd10);
    check("wall_up_dir", 32'(p1_dir), 32'd0);
    check("wall_up_reads", 32'(nrd), 32'd1);
    check("wall_up_latency", 32'(lat), 32'd6);
    wall[1][8] = 1'b0;

    repeat (2) do_step(C_UP, C_NONE, 1'b0, lat, nrd);
    repeat (8) do_step(C_LEFT, C_NONE, 1'b0, lat, nrd);
    check_pos("corner", 4'd0, 5'd0, 4'd7, 5'd10);

    do_step(C_LEFT, C_NONE, 1'b0, lat, nrd);
    check_pos("oob_left", 4'd0, 5'd0, 4'd7, 5'd10);
    check("oob_left_dir", 32'(p1_dir), 32'd2);
    check("oob_left_reads", 32'(nrd), 32'd0);
    check("oob_left_latency", 32'(lat), 32'd4);
    do_step(C_UP, C_NONE, 1'b0, lat, nrd);
    check("oob_up_dir", 32'(p1_dir), 32'd0);
    check("oob_up_reads", 32'(nrd), 32'd0);

    for (int i = 0; i < 5; i++) do_step(C_DOWN, (i < 2) ? C_UP : C_NONE, 1'b0, lat, nrd);
    for (int i = 0; i < 3; i++) do_step(C_RIGHT, (i == 0) ? C_LEFT : C_NONE, 1'b0, lat, nrd);
    check_pos("shoot_setup", 4'd5, 5'd3, 4'd5, 5'd9);
    check("shoot_setup_dir", 32'(p1_dir), 32'd3);

    wall[5][6] = 1'b1;
    do_step(C_SHOOT, C_LEFT, 1'b0, lat, nrd);
    check("miss_victory", 32'(victory), 32'd0);
    check_pos("miss", 4'd5, 5'd3, 4'd5, 5'd8);
    check("miss_p1_dir", 32'(p1_dir), 32'd3);
    check("miss_reads", 32'(nrd), 32'd4);
    check("miss_latency", 32'(lat), 32'd12);
    wall[5][6] = 1'b0;

    do_step(C_NONE, C_RIGHT, 1'b0, lat, nrd);
    check_pos("reposition", 4'd5, 5'd3, 4'd5, 5'd9);

    do_step(C_SHOOT, C_LEFT, 1'b0, lat, nrd);
    check("hit_victory", 32'(victory), 32'd1);
    check_pos("hit", 4'd5, 5'd3, 4'd5, 5'd9);
    check("hit_p2_dir", 32'(p2_dir), 32'd3);
    check("hit_reads", 32'(nrd), 32'd5);
    check("hit_latency", 32'(lat), 32'd11);

    rd0    = rd_cnt;
    p1_cmd = C_RIGHT;
    p2_cmd = C_LEFT;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    check("won_tick_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("won_tick_done", 32'(step_done), 32'd0);
    check("won_tick_reads", 32'(rd_cnt - rd0), 32'd0);
    check("won_victory_sticky", 32'(victory), 32'd1);
    check_pos("won_tick", 4'd5, 5'd3, 4'd5, 5'd9);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_clear_victory", 32'(victory), 32'd0);
    do_step(C_RIGHT, C_NONE, 1'b0, lat, nrd);
    check_pos("pre_abort", 4'd2, 5'd9, 4'd8, 5'd10);

    p1_cmd = C_SHOOT;
    p2_cmd = C_NONE;
    tick   = 1'b1;
    @(posedge clk); #1;
    tick  = 1'b0;
    guard = 0;
    while ((mif.maze_rd_en !== 1'b1) && (guard < 20)) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_scan_started", 32'(guard < 20), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_victory", 32'(victory), 32'd0);
    check("abort_rd_en", 32'(mif.maze_rd_en), 32'd0);
    check("abort_p1_dir", 32'(p1_dir), 32'd0);
    check_pos("abort", 4'd2, 5'd8, 4'd8, 5'd10);
    rst = 1'b0;
    @(posedge clk); #1;

    do_step(C_NONE, C_NONE, 1'b0, lat, nrd);
    check("recover_latency", 32'(lat), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
